// File: rtl/mmio_io_ctrl_gen2.sv
`default_nettype none
// ============================================================================
// Module   : mmio_io_ctrl_gen2
// Purpose  : Single-page MMIO I/O controller for the core data bus. Provides
//            LED / 7-segment / switch registers, per-key debounce with press
//            and release events, a maskable level interrupt and a per-digit
//            7-segment blink engine.
// Ports    : i_clk, i_rst (sync, active-high)
//            i_we, i_addr, i_wdata (unshifted), i_size -> store interface
//            o_rdata                                    -> combinational read
//            i_sw, i_key                                -> raw board inputs
//            o_ledr, o_ledg, o_hex (active-low gfedcba) -> board outputs
//            o_irq                                      -> registered level IRQ
// Revision : 1.0 - initial release
// ============================================================================
module mmio_io_ctrl_gen2 #(
    parameter logic [31:0] P_BASE    = 32'h1000_0000,
    parameter int          N_KEYS    = 4,
    parameter int          N_SW      = 18,
    parameter int          N_LEDR    = 18,
    parameter int          N_LEDG    = 9,
    parameter int          DB_CYCLES = 50000,
    parameter int          BLINK_DIV = 25000000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_wdata,
    input  logic [2:0]        i_size,
    output logic [31:0]       o_rdata,
    input  logic [N_SW-1:0]   i_sw,
    input  logic [N_KEYS-1:0] i_key,
    output logic [N_LEDR-1:0] o_ledr,
    output logic [N_LEDG-1:0] o_ledg,
    output logic [55:0]       o_hex,
    output logic              o_irq
);

    localparam int c_DB_W = $clog2(DB_CYCLES);
    localparam int c_BL_W = $clog2(BLINK_DIV);
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DB_CYCLES - 1);
    localparam logic [c_BL_W-1:0] c_BL_LAST = c_BL_W'(BLINK_DIV - 1);

    localparam logic [9:0] c_OFS_LEDR   = 10'd0;
    localparam logic [9:0] c_OFS_LEDG   = 10'd1;
    localparam logic [9:0] c_OFS_HEX_LO = 10'd2;
    localparam logic [9:0] c_OFS_HEX_HI = 10'd3;
    localparam logic [9:0] c_OFS_SW     = 10'd4;
    localparam logic [9:0] c_OFS_KEY    = 10'd5;
    localparam logic [9:0] c_OFS_KEY_EV = 10'd6;
    localparam logic [9:0] c_OFS_KEY_IE = 10'd7;
    localparam logic [9:0] c_OFS_BLINK  = 10'd8;

    // Register state
    logic [31:0]       r_ledr;
    logic [31:0]       r_ledg;
    logic [55:0]       r_hex;        // digit k at [7k+6:7k]
    logic [7:0]        r_blink;
    logic [N_KEYS-1:0] r_ev_press, r_ev_rel;
    logic [N_KEYS-1:0] r_ie_press, r_ie_rel;
    logic [N_KEYS-1:0] r_stable;
    logic [c_BL_W-1:0] r_bcnt;
    logic              r_phase;
    logic              r_irq;

    // Bus decode
    logic        w_hit, w_wr;
    logic [9:0]  w_ofs;
    logic [3:0]  w_lane;
    logic [31:0] w_wdata_sh, w_bmask;

    assign w_hit = (i_addr & 32'hFFFF_F000) == P_BASE;
    assign w_wr  = i_we & w_hit;
    assign w_ofs = i_addr[11:2];

    // Store data arrives unshifted: replicate it across the lanes so the lane
    // mask alone selects where it lands.
    always_comb begin
        w_lane     = 4'b0000;
        w_wdata_sh = i_wdata;
        case (i_size)
            3'd0: begin
                w_lane     = 4'b0001 << i_addr[1:0];
                w_wdata_sh = {4{i_wdata[7:0]}};
            end
            3'd1: begin
                w_lane     = i_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_sh = {2{i_wdata[15:0]}};
            end
            3'd2:    w_lane = 4'b1111;
            default: w_lane = 4'b0000;
        endcase
    end

    assign w_bmask = {{8{w_lane[3]}}, {8{w_lane[2]}}, {8{w_lane[1]}}, {8{w_lane[0]}}};

    // Register views in bus format, and their lane-merged write values
    logic [31:0] w_hexlo_rd, w_hexhi_rd, w_ev_rd, w_ie_rd;
    logic [31:0] w_m_hexlo, w_m_hexhi, w_m_ie, w_clr;
    logic [27:0] w_hexlo_wr, w_hexhi_wr;
    logic [55:0] w_hex_disp;

    assign w_ev_rd   = 32'(r_ev_press) | (32'(r_ev_rel) << 16);
    assign w_ie_rd   = 32'(r_ie_press) | (32'(r_ie_rel) << 16);
    assign w_m_hexlo = (w_hexlo_rd & ~w_bmask) | (w_wdata_sh & w_bmask);
    assign w_m_hexhi = (w_hexhi_rd & ~w_bmask) | (w_wdata_sh & w_bmask);
    assign w_m_ie    = (w_ie_rd    & ~w_bmask) | (w_wdata_sh & w_bmask);
    assign w_clr     = w_wdata_sh & w_bmask;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_hex_fmt
            assign w_hexlo_rd[8*gi +: 8] = {1'b0, r_hex[7*gi +: 7]};
            assign w_hexhi_rd[8*gi +: 8] = {1'b0, r_hex[7*(gi+4) +: 7]};
            assign w_hexlo_wr[7*gi +: 7] = w_m_hexlo[8*gi +: 7];
            assign w_hexhi_wr[7*gi +: 7] = w_m_hexhi[8*gi +: 7];
        end
        for (gi = 0; gi < 8; gi++) begin : g_blink
            assign w_hex_disp[7*gi +: 7] = (r_blink[gi] & r_phase) ? 7'h7F : r_hex[7*gi +: 7];
        end
    endgenerate

    // Key debounce: count consecutive synchronised samples that disagree with
    // the accepted level; any agreeing sample restarts the count.
    logic [N_KEYS-1:0] w_s, w_accept;

    generate
        for (gi = 0; gi < N_KEYS; gi++) begin : g_key
            logic [1:0]        r_sync;
            logic [c_DB_W-1:0] r_cnt;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_sync <= 2'b00;
                    r_cnt  <= '0;
                end else begin
                    r_sync <= {r_sync[0], i_key[gi]};
                    if (r_sync[1] == r_stable[gi] || r_cnt == c_DB_LAST)
                        r_cnt <= '0;
                    else
                        r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_s[gi]      = r_sync[1];
            assign w_accept[gi] = (r_sync[1] != r_stable[gi]) && (r_cnt == c_DB_LAST);
        end
    endgenerate

    logic [N_KEYS-1:0] w_clr_press, w_clr_rel;
    assign w_clr_press = (w_wr && w_ofs == c_OFS_KEY_EV) ? w_clr[N_KEYS-1:0]   : '0;
    assign w_clr_rel   = (w_wr && w_ofs == c_OFS_KEY_EV) ? w_clr[16 +: N_KEYS] : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ledr     <= '0;
            r_ledg     <= '0;
            r_hex      <= {8{7'h7F}};
            r_blink    <= '0;
            r_ev_press <= '0;
            r_ev_rel   <= '0;
            r_ie_press <= '0;
            r_ie_rel   <= '0;
            r_stable   <= '0;
            r_bcnt     <= '0;
            r_phase    <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_stable <= r_stable ^ w_accept;
            // Hardware set is ORed in after the clear so a coincident set wins
            r_ev_press <= (r_ev_press & ~w_clr_press) | (w_accept & w_s);
            r_ev_rel   <= (r_ev_rel   & ~w_clr_rel)   | (w_accept & ~w_s);
            r_irq      <= |((r_ev_press & r_ie_press) | (r_ev_rel & r_ie_rel));

            if (r_bcnt == c_BL_LAST) begin
                r_bcnt  <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_bcnt <= r_bcnt + 1'b1;
            end

            if (w_wr) begin
                case (w_ofs)
                    c_OFS_LEDR:   r_ledr <= (r_ledr & ~w_bmask) | (w_wdata_sh & w_bmask);
                    c_OFS_LEDG:   r_ledg <= (r_ledg & ~w_bmask) | (w_wdata_sh & w_bmask);
                    c_OFS_HEX_LO: r_hex[27:0]  <= w_hexlo_wr;
                    c_OFS_HEX_HI: r_hex[55:28] <= w_hexhi_wr;
                    c_OFS_KEY_IE: begin
                        r_ie_press <= w_m_ie[N_KEYS-1:0];
                        r_ie_rel   <= w_m_ie[16 +: N_KEYS];
                    end
                    c_OFS_BLINK:  r_blink <= (r_blink & ~w_bmask[7:0]) | (w_wdata_sh[7:0] & w_bmask[7:0]);
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        if (w_hit) begin
            case (w_ofs)
                c_OFS_LEDR:   o_rdata = r_ledr;
                c_OFS_LEDG:   o_rdata = r_ledg;
                c_OFS_HEX_LO: o_rdata = w_hexlo_rd;
                c_OFS_HEX_HI: o_rdata = w_hexhi_rd;
                c_OFS_SW:     o_rdata = 32'(i_sw);
                c_OFS_KEY:    o_rdata = 32'(r_stable);
                c_OFS_KEY_EV: o_rdata = w_ev_rd;
                c_OFS_KEY_IE: o_rdata = w_ie_rd;
                c_OFS_BLINK:  o_rdata = {24'd0, r_blink};
                default:      o_rdata = '0;
            endcase
        end
    end

    // Merged words are only partly consumed (bit 7 of HEX bytes, unused IE bits)
    logic w_unused;
    assign w_unused = ^{w_m_ie, w_m_hexlo, w_m_hexhi, w_clr};

    assign o_ledr = r_ledr[N_LEDR-1:0];
    assign o_ledg = r_ledg[N_LEDG-1:0];
    assign o_hex  = i_rst ? {56{1'b1}} : w_hex_disp;
    assign o_irq  = r_irq;

endmodule
`default_nettype wire
